fetch_unit: RTL

- Instruction fetch stage directly upstream of the single-cycle core.
- Owns the fetch PC and issues word requests to the instruction ROM port, which has a one-cycle read latency.
- Buffers returned words in a small prefetch FIFO.
- Presents each instruction with its PC, PC+4 and PC+8 to the core's decode, register-file and r15 paths.
- Handles branch redirects from the core by flushing the FIFO and discarding in-flight responses.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, keeps at most one ROM read in flight
// and buffers returned words in a small prefetch FIFO for the core.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_gnt,
  input  logic        rom_rvalid,
  input  logic [31:0] rom_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_plus8,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          out_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];

  logic        grant;
  logic        push;
  logic        pop;
  logic        out_d;
  logic [CW:0] in_use;
  logic        unused_tgt_lsb;

  assign unused_tgt_lsb = ^branch_target[1:0];

  // Slots already promised: buffered words plus the read in flight.
  assign in_use = {1'b0, count_q} + {{CW{1'b0}}, out_q};

  assign instr_valid = (count_q != '0);
  assign rom_addr    = fetch_pc_q;
  assign rom_req     = (state_q == RUN) && !halt && (in_use < DEPTH_C);

  assign grant = rom_req && rom_gnt;
  assign push  = out_q && rom_rvalid && (state_q == RUN) && !branch_taken;
  assign pop   = instr_valid && instr_ready && !branch_taken;
  assign out_d = grant || (out_q && !rom_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      out_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (branch_taken) begin
      fetch_pc_q <= {branch_target[31:2], 2'b00};
      out_q      <= out_d;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= out_d ? DRAIN : RUN;
    end else begin
      if (grant) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        req_pc_q   <= fetch_pc_q;
      end
      out_q <= out_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     state_q <= RUN;
        DRAIN:   if (out_q && rom_rvalid) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= rom_rdata;
      mem_pc[wr_ptr_q]    <= req_pc_q;
    end
  end

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    pc_plus4 = '0;
    pc_plus8 = '0;
    if (instr_valid) begin
      instr    = mem_instr[rd_ptr_q];
      instr_pc = mem_pc[rd_ptr_q];
      pc_plus4 = mem_pc[rd_ptr_q] + 32'd4;
      pc_plus8 = mem_pc[rd_ptr_q] + 32'd8;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) assert ({1'b0, count_q} <= DEPTH_C);
  end
`endif

endmodule
